card_dealer: RTL and testbench
==============================

CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 draw_req  input  1  single-cycle pulse from debounced button stage; requests one card.
REQ-004 shuffle  input  1  single-cycle pulse; returns all 52 cards to the deck.
REQ-005 card_valid  output  1  registered one-cycle pulse; card_rank/card_half valid this cycle.
REQ-006 card_rank  output  4  rank 1..13 (A=1, J=11, Q=12, K=13); holds last dealt value.
REQ-007 card_half  output  5  game value in half-points: rank*2 for rank 1..10, 1 for J/Q/K.
REQ-008 cards_left  output  6  undealt cards, 0..52.
REQ-009 deck_empty  output  1  high when cards_left == 0.
REQ-010 busy  output  1  high while a search is in progress.

Function
REQ-011 Deck SHALL be 52 slots, index 0..51; rank = idx mod 13 + 1; suit = idx / 13 (internal only).
REQ-012 A 52-bit used mask SHALL mark dealt slots; a slot SHALL NOT be dealt twice between shuffles.
REQ-013 A 6-bit Fibonacci LFSR (x^6+x^5+1, seed 6'b000001) SHALL advance every cycle, including IDLE.
REQ-014 FSM states SHALL be IDLE and SEARCH only.
REQ-015 IDLE + draw_req + !deck_empty: ptr <= start index, go to SEARCH, busy <= 1.
REQ-016 Start index = LFSR value if < 52, else LFSR - 52.
REQ-017 SEARCH: if used[ptr] == 0, set used[ptr], load rank/half, pulse card_valid next cycle, decrement cards_left, return to IDLE; else ptr <= (ptr == 51) ? 0 : ptr + 1.
REQ-018 Latency SHALL be 2 cycles from the draw_req edge to card_valid when the start slot is free, plus 1 cycle per used slot skipped; worst case 53.
REQ-019 draw_req while busy SHALL be ignored, not queued.
REQ-020 draw_req while deck_empty SHALL be ignored; no card_valid; state stays IDLE.
REQ-021 shuffle SHALL clear the used mask, set cards_left to 52, clear deck_empty, and force IDLE in the next cycle.
REQ-022 shuffle during SEARCH SHALL abort the search with no card_valid; shuffle and draw_req in the same cycle: shuffle wins, draw dropped.
REQ-023 card_rank/card_half SHALL change only with card_valid; LFSR is not reset by shuffle.

Reset
REQ-024 Under reset: state IDLE, used mask all 0, cards_left 52, deck_empty 0, busy 0, card_valid 0, card_rank 0, card_half 0, LFSR 6'b000001.
REQ-025 Reset asserted mid-SEARCH SHALL abort immediately; no card_valid after release until a new draw_req.

Configuration
REQ-026 Macro DEALER_DEBUG_SEQ_EN defined: start index SHALL always be 0, so cards are dealt in index order 0,1,2,...; LFSR still runs but is unused.
REQ-027 Macro absent: start index from LFSR per REQ-016.

Structure
REQ-028 Package dealer_pkg SHALL hold DECK_SIZE=52, NUM_RANKS=13, LFSR seed/taps, the state enum, and the idx->rank and rank->half-point functions.
REQ-029 Sub-module dealer_lfsr (6-bit LFSR, enable-free, async reset to seed) SHALL be the only child instance.

Verification (DEALER_DEBUG_SEQ_EN defined unless noted)
REQ-030 Reset release, draw_req at cycle N -> card_valid at N+2, rank 1, half 2, cards_left 51, busy low at N+2.
REQ-031 11 spaced draws -> 11th gives rank 11, half 1, latency 12 cycles; 13th gives rank 13, 14th gives rank 1, half 2.
REQ-032 52 draws -> deck_empty 1, cards_left 0; 53rd draw_req -> no card_valid for 60 cycles.
REQ-033 shuffle in 2nd cycle of a SEARCH -> no card_valid, cards_left 52; next draw -> rank 1.
REQ-034 draw_req repeated while busy -> exactly one card_valid; shuffle+draw_req same cycle -> no card_valid.
REQ-035 Macro undefined: 52 draws -> each idx 0..51 dealt exactly once (scoreboard), each rank seen 4 times.

Source files
------------

// File: rtl/dealer_pkg.sv
// Shared constants, FSM state type and card-value helpers for the card dealer.
package dealer_pkg;

   localparam int          DECK_SIZE  = 52;
   localparam int          NUM_RANKS  = 13;
   localparam int          LFSR_W     = 6;
   localparam logic [5:0]  LFSR_SEED  = 6'b000001;
   // Feedback taps for x^6 + x^5 + 1: bits 5 and 4 of the shift register.
   localparam logic [5:0]  LFSR_TAPS  = 6'b110000;
   localparam logic [5:0]  DECK_CNT   = 6'd52;
   localparam logic [5:0]  LAST_IDX   = 6'd51;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SEARCH = 1'b1
   } state_t;

   // Slot index 0..51 to rank 1..13; suits are stacked in blocks of 13.
   function automatic logic [3:0] idx_to_rank(input logic [5:0] idx);
      logic [5:0] r;
      r = idx;
      if (r >= 6'd39)
         r = r - 6'd39;
      else if (r >= 6'd26)
         r = r - 6'd26;
      else if (r >= 6'd13)
         r = r - 6'd13;
      return 4'(r + 6'd1);
   endfunction

   // Face cards are worth half a point; everything else is its rank.
   function automatic logic [4:0] rank_to_half(input logic [3:0] rank);
      return (rank > 4'd10) ? 5'd1 : {rank, 1'b0};
   endfunction

endpackage

// File: rtl/dealer_lfsr.sv
// Free-running 6-bit Fibonacci LFSR (x^6 + x^5 + 1), asynchronously reset to the seed.
module dealer_lfsr
   import dealer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   output logic [LFSR_W-1:0] o_lfsr
);

   logic [LFSR_W-1:0] r_lfsr;
   logic              w_fb;

   assign w_fb   = ^(r_lfsr & LFSR_TAPS);
   assign o_lfsr = r_lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_lfsr <= LFSR_SEED;
      else
         r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
   end

endmodule

// File: rtl/card_dealer.sv
// Deals cards from a 52-slot deck without repeats until shuffled.
// DEALER_DEBUG_SEQ_EN: every search starts at slot 0, dealing cards in index order.
module card_dealer
   import dealer_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       draw_req,
   input  logic       shuffle,
   output logic       card_valid,
   output logic [3:0] card_rank,
   output logic [4:0] card_half,
   output logic [5:0] cards_left,
   output logic       deck_empty,
   output logic       busy
);

   // Handshake: draw_req and shuffle are single-cycle pulses with no ready;
   // a draw is accepted only in IDLE with cards remaining, otherwise dropped.
   // card_valid is a one-cycle pulse; rank/half hold until the next pulse.

   state_t              r_state;
   logic [DECK_SIZE-1:0] r_used;
   logic [5:0]          r_ptr;
   logic [5:0]          r_cards_left;
   logic                r_deck_empty;
   logic                r_busy;
   logic                r_card_valid;
   logic [3:0]          r_card_rank;
   logic [4:0]          r_card_half;

   logic [LFSR_W-1:0]   w_lfsr;
   logic [5:0]          w_start;
   logic [3:0]          w_rank;

   dealer_lfsr u_lfsr (
      .clk    (clk),
      .rst_n  (rst_n),
      .o_lfsr (w_lfsr)
   );

`ifdef DEALER_DEBUG_SEQ_EN
   assign w_start = 6'd0;
`else
   // LFSR never reaches 0 and tops out at 63, so one fold lands in 0..51.
   assign w_start = (w_lfsr < DECK_CNT) ? w_lfsr : (w_lfsr - DECK_CNT);
`endif

   assign w_rank = idx_to_rank(r_ptr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_used       <= '0;
         r_ptr        <= 6'd0;
         r_cards_left <= DECK_CNT;
         r_deck_empty <= 1'b0;
         r_busy       <= 1'b0;
         r_card_valid <= 1'b0;
         r_card_rank  <= 4'd0;
         r_card_half  <= 5'd0;
      end else begin
         r_card_valid <= 1'b0;
         if (shuffle) begin
            // Shuffle outranks any draw or search in flight.
            r_used       <= '0;
            r_cards_left <= DECK_CNT;
            r_deck_empty <= 1'b0;
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (draw_req && !r_deck_empty) begin
                     r_ptr   <= w_start;
                     r_state <= ST_SEARCH;
                     r_busy  <= 1'b1;
                  end
               end
               ST_SEARCH: begin
                  if (!r_used[r_ptr]) begin
                     r_used[r_ptr] <= 1'b1;
                     r_card_rank   <= w_rank;
                     r_card_half   <= rank_to_half(w_rank);
                     r_card_valid  <= 1'b1;
                     r_cards_left  <= r_cards_left - 6'd1;
                     r_deck_empty  <= (r_cards_left == 6'd1);
                     r_state       <= ST_IDLE;
                     r_busy        <= 1'b0;
                  end else begin
                     r_ptr <= (r_ptr == LAST_IDX) ? 6'd0 : (r_ptr + 6'd1);
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign card_valid = r_card_valid;
   assign card_rank  = r_card_rank;
   assign card_half  = r_card_half;
   assign cards_left = r_cards_left;
   assign deck_empty = r_deck_empty;
   assign busy       = r_busy;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer against a deck-level reference model.
module tb_card_dealer;

   logic       clk;
   logic       rst_n;
   logic       draw_req;
   logic       shuffle;
   logic       card_valid;
   logic [3:0] card_rank;
   logic [4:0] card_half;
   logic [5:0] cards_left;
   logic       deck_empty;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [5:0] m_lfsr;
   bit         m_used[52];
   int         m_left;
   int         rank_cnt[14];
   int         deal_cnt[52];
   logic [3:0] last_rank;
   logic [4:0] last_half;
   logic [8:0] exp_q[$];

   card_dealer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .draw_req   (draw_req),
      .shuffle    (shuffle),
      .card_valid (card_valid),
      .card_rank  (card_rank),
      .card_half  (card_half),
      .cards_left (cards_left),
      .deck_empty (deck_empty),
      .busy       (busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Polynomial x^6+x^5+1: new LSB is the XOR of the two top bits.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         m_lfsr <= 6'd1;
      else
         m_lfsr <= ((m_lfsr * 2) % 64) | ((m_lfsr / 32) ^ ((m_lfsr / 16) % 2));
   end

   task automatic model_clear_deck();
      for (int i = 0; i < 52; i++) m_used[i] = 1'b0;
      m_left = 52;
   endtask

   task automatic apply_reset();
      draw_req = 1'b0;
      shuffle  = 1'b0;
      rst_n    = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_clear_deck();
      last_rank = 4'd0;
      last_half = 5'd0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_draw(input int gap);
      int start, idx, skip, lat;
      bit got;
      logic [3:0] er;
      logic [4:0] eh;
      logic [8:0] e;
      repeat (gap) @(negedge clk);
`ifdef DEALER_DEBUG_SEQ_EN
      start = 0;
`else
      start = (int'(m_lfsr) < 52) ? int'(m_lfsr) : int'(m_lfsr) - 52;
`endif
      idx = start;
      skip = 0;
      while (m_used[idx]) begin
         idx = (idx + 1) % 52;
         skip++;
      end
      er = 4'(idx % 13 + 1);
      eh = (er <= 4'd10) ? 5'(er * 2) : 5'd1;
      exp_q.push_back({er, eh});
      draw_req = 1'b1;
      got = 1'b0;
      lat = 0;
      for (int c = 0; c < 60 && !got; c++) begin
         @(negedge clk);
         draw_req = 1'b0;
         lat++;
         if (lat == 1) begin
            n_checks++;
            if (busy !== 1'b1) begin
               n_fail++;
               $display("FAIL busy_during_search: got %b want 1", busy);
            end
         end
         if (card_valid === 1'b1) got = 1'b1;
      end
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL draw_timeout: no card_valid within 60 cycles (expected idx %0d)", idx);
         void'(exp_q.pop_front());
         return;
      end
      e = exp_q.pop_front();
      m_used[idx] = 1'b1;
      m_left--;
      rank_cnt[er]++;
      deal_cnt[idx]++;
      last_rank = er;
      last_half = eh;
      n_checks++;
      if (lat !== 2 + skip) begin
         n_fail++;
         $display("FAIL draw_latency: got %0d want %0d (idx %0d)", lat, 2 + skip, idx);
      end
      n_checks++;
      if ({card_rank, card_half} !== e) begin
         n_fail++;
         $display("FAIL card_value: got rank %0d half %0d want rank %0d half %0d",
                  card_rank, card_half, e[8:5], e[4:0]);
      end
      n_checks++;
      if (cards_left !== 6'(m_left) || deck_empty !== (m_left == 0) || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL post_draw_status: got left %0d empty %b busy %b want left %0d empty %b busy 0",
                  cards_left, deck_empty, busy, m_left, (m_left == 0));
      end
      @(negedge clk);
      n_checks++;
      if (card_valid !== 1'b0 || card_rank !== last_rank) begin
         n_fail++;
         $display("FAIL valid_pulse_width: got valid %b rank %0d want valid 0 rank %0d",
                  card_valid, card_rank, last_rank);
      end
   endtask

   task automatic expect_quiet(input string tag, input int cycles);
      int nv;
      nv = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         draw_req = 1'b0;
         shuffle  = 1'b0;
         if (card_valid === 1'b1) nv++;
      end
      n_checks++;
      if (nv != 0) begin
         n_fail++;
         $display("FAIL %s: got %0d card_valid pulses want 0", tag, nv);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      draw_req = 1'b0;
      shuffle = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (card_valid !== 1'b0 || card_rank !== 4'd0 || card_half !== 5'd0 ||
          cards_left !== 6'd52 || deck_empty !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: got v%b r%0d h%0d left%0d empty%b busy%b want v0 r0 h0 left52 empty0 busy0",
                  card_valid, card_rank, card_half, cards_left, deck_empty, busy);
      end
      apply_reset();
   endtask

   task automatic test_full_deck();
      int nb;
      for (int i = 0; i < 14; i++) rank_cnt[i] = 0;
      for (int i = 0; i < 52; i++) deal_cnt[i] = 0;
      for (int d = 0; d < 52; d++) do_draw($urandom_range(0, 4));
      for (int r = 1; r <= 13; r++) begin
         n_checks++;
         if (rank_cnt[r] != 4) begin
            n_fail++;
            $display("FAIL rank_count: rank %0d seen %0d times want 4", r, rank_cnt[r]);
         end
      end
      for (int i = 0; i < 52; i++) begin
         if (deal_cnt[i] != 1) begin
            n_checks++;
            n_fail++;
            $display("FAIL slot_count: slot %0d dealt %0d times want 1", i, deal_cnt[i]);
         end
      end
      n_checks++;
      if (deck_empty !== 1'b1 || cards_left !== 6'd0) begin
         n_fail++;
         $display("FAIL deck_exhausted: got empty %b left %0d want empty 1 left 0", deck_empty, cards_left);
      end
      // Extra draw on an empty deck must be dropped.
      draw_req = 1'b1;
      nb = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         draw_req = 1'b0;
         if (busy === 1'b1) nb++;
         n_checks++;
         if (card_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_draw: got card_valid 1 at cycle %0d want 0", c);
         end
      end
      n_checks++;
      if (nb != 0) begin
         n_fail++;
         $display("FAIL empty_draw_busy: got %0d busy cycles want 0", nb);
      end
   endtask

   task automatic test_shuffle_abort();
      shuffle = 1'b1;
      @(negedge clk);
      shuffle = 1'b0;
      model_clear_deck();
      n_checks++;
      if (cards_left !== 6'd52 || deck_empty !== 1'b0) begin
         n_fail++;
         $display("FAIL shuffle_refill: got left %0d empty %b want 52 0", cards_left, deck_empty);
      end
      repeat ($urandom_range(2, 6)) do_draw($urandom_range(0, 3));
      draw_req = 1'b1;
      @(negedge clk);
      draw_req = 1'b0;
      shuffle = 1'b1;
      @(negedge clk);
      shuffle = 1'b0;
      model_clear_deck();
      n_checks++;
      if (card_valid !== 1'b0 || busy !== 1'b0 || cards_left !== 6'd52 || card_rank !== last_rank) begin
         n_fail++;
         $display("FAIL shuffle_abort: got v%b busy%b left%0d rank%0d want v0 busy0 left52 rank%0d",
                  card_valid, busy, cards_left, card_rank, last_rank);
      end
      expect_quiet("shuffle_abort_quiet", 10);
      do_draw(1);
   endtask

   task automatic test_busy_ignore();
      int nv, start, idx;
      logic [3:0] er;
`ifdef DEALER_DEBUG_SEQ_EN
      start = 0;
`else
      start = (int'(m_lfsr) < 52) ? int'(m_lfsr) : int'(m_lfsr) - 52;
`endif
      idx = start;
      while (m_used[idx]) idx = (idx + 1) % 52;
      er = 4'(idx % 13 + 1);
      draw_req = 1'b1;
      @(negedge clk);
      nv = 0;
      // Keep requesting during the search cycle; it must not queue a second card.
      draw_req = busy ? 1'b1 : 1'b0;
      @(negedge clk);
      draw_req = 1'b0;
      if (card_valid === 1'b1) nv++;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (card_valid === 1'b1) nv++;
      end
      m_used[idx] = 1'b1;
      m_left--;
      last_rank = er;
      n_checks++;
      if (nv != 1) begin
         n_fail++;
         $display("FAIL busy_ignore: got %0d card_valid pulses want 1", nv);
      end
      n_checks++;
      if (card_rank !== er || cards_left !== 6'(m_left)) begin
         n_fail++;
         $display("FAIL busy_ignore_card: got rank %0d left %0d want rank %0d left %0d",
                  card_rank, cards_left, er, m_left);
      end
   endtask

   task automatic test_shuffle_with_draw();
      draw_req = 1'b1;
      shuffle  = 1'b1;
      @(negedge clk);
      model_clear_deck();
      expect_quiet("shuffle_draw_same_cycle", 10);
      n_checks++;
      if (cards_left !== 6'd52 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL shuffle_draw_status: got left %0d busy %b want 52 0", cards_left, busy);
      end
   endtask

   task automatic test_reset_mid_search();
      do_draw(0);
      do_draw(2);
      draw_req = 1'b1;
      @(negedge clk);
      draw_req = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || cards_left !== 6'd52 || card_rank !== 4'd0) begin
         n_fail++;
         $display("FAIL async_reset: got busy %b left %0d rank %0d want 0 52 0", busy, cards_left, card_rank);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear_deck();
      last_rank = 4'd0;
      expect_quiet("reset_mid_search_quiet", 20);
      do_draw(0);
   endtask

   task automatic test_back_to_back();
      for (int d = 0; d < 8; d++) do_draw(0);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      repeat ($urandom_range(1, 5)) @(negedge clk);
      test_full_deck();
      test_shuffle_abort();
      test_busy_ignore();
      test_shuffle_with_draw();
      test_back_to_back();
      test_reset_mid_search();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
